// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared types and constants for the local-store access controller
package ls_pkg;
  typedef enum logic [1:0] {IDLE, XFER, RESP} ls_state_e;
  typedef enum logic {REQ_SPU = 1'b0, REQ_DMA = 1'b1} req_id_e;
  localparam int BEATS  = 4;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/ls_rr_arb.sv
// rtl/ls_rr_arb.sv - 2-way round-robin arbiter; grant[0]=SPU, grant[1]=DMA
module ls_rr_arb
  import ls_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_e rr_last;

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant = req;
    if (&req) grant = (rr_last == REQ_DMA) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last <= REQ_DMA;
    end else if (advance && |grant) begin
      rr_last <= grant[1] ? REQ_DMA : REQ_SPU;
    end
  end

endmodule

// File: rtl/ls_access_ctrl.sv
// rtl/ls_access_ctrl.sv - shares the byte-wide local store between SPU and DMA, big-endian beats
// Optional: LS_MISALIGN_ERR_EN reports unaligned requests as errors instead of forcing alignment.
module ls_access_ctrl
  import ls_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_req_valid,
  output logic             s_req_ready,
  input  logic             s_req_we,
  input  logic [WIDTH-1:0] s_req_adr,
  input  logic [WIDTH-1:0] s_req_wdata,
  output logic             s_rsp_valid,
  input  logic             s_rsp_ready,
  output logic [WIDTH-1:0] s_rsp_rdata,
  output logic             s_rsp_err,
  input  logic             d_req_valid,
  output logic             d_req_ready,
  input  logic             d_req_we,
  input  logic [WIDTH-1:0] d_req_adr,
  input  logic [WIDTH-1:0] d_req_wdata,
  output logic             d_rsp_valid,
  input  logic             d_rsp_ready,
  output logic [WIDTH-1:0] d_rsp_rdata,
  output logic             d_rsp_err,
  input  logic [WIDTH-1:0] memdata,
  output logic             memread,
  output logic             memwrite,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata
);

  ls_state_e        state;
  req_id_e          owner;
  logic             we;
  logic             err;
  logic [1:0]       beat;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  logic [1:0]       req;
  logic [1:0]       grant;
  logic             sel_we;
  logic             sel_mis;
  logic [WIDTH-1:0] sel_adr;
  logic [WIDTH-1:0] sel_wdata;
  logic             xfer;
  logic             rsp_accept;
  int               lane_msb;
  logic             mem_hi_unused;

  assign req = (state == IDLE) ? {d_req_valid, s_req_valid} : 2'b00;

  ls_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (state == IDLE),
    .grant   (grant)
  );

  assign s_req_ready = grant[0];
  assign d_req_ready = grant[1];

  assign sel_we    = grant[1] ? d_req_we    : s_req_we;
  assign sel_adr   = grant[1] ? d_req_adr   : s_req_adr;
  assign sel_wdata = grant[1] ? d_req_wdata : s_req_wdata;

`ifdef LS_MISALIGN_ERR_EN
  assign sel_mis = (sel_adr[1:0] != 2'b00);
`else
  assign sel_mis = 1'b0;
`endif

  assign rsp_accept = (owner == REQ_SPU) ? s_rsp_ready : d_rsp_ready;
  assign lane_msb   = WIDTH - 1 - BYTE_W * int'(beat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= REQ_SPU;
      we    <= 1'b0;
      err   <= 1'b0;
      beat  <= 2'd0;
      base  <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            owner <= grant[1] ? REQ_DMA : REQ_SPU;
            we    <= sel_we;
            base  <= sel_adr & ~WIDTH'(3);
            wdata <= sel_wdata;
            rdata <= '0;
            err   <= sel_mis;
            beat  <= 2'd0;
            state <= sel_mis ? RESP : XFER;
          end
        end
        XFER: begin
          if (!we) rdata[lane_msb -: BYTE_W] <= memdata[BYTE_W-1:0];
          beat <= beat + 2'd1;
          if (beat == 2'(BEATS - 1)) state <= RESP;
        end
        RESP: begin
          if (rsp_accept) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs decode straight from state so reset removes them immediately.
  assign xfer      = (state == XFER);
  assign adr       = xfer ? base + WIDTH'(beat) : '0;
  assign memread   = xfer && !we;
  assign memwrite  = xfer && we;
  assign writedata = (xfer && we) ? {{(WIDTH-BYTE_W){1'b0}}, wdata[lane_msb -: BYTE_W]} : '0;

  assign s_rsp_valid = (state == RESP) && (owner == REQ_SPU);
  assign d_rsp_valid = (state == RESP) && (owner == REQ_DMA);
  assign s_rsp_rdata = s_rsp_valid ? rdata : '0;
  assign d_rsp_rdata = d_rsp_valid ? rdata : '0;
  assign s_rsp_err   = s_rsp_valid && err;
  assign d_rsp_err   = d_rsp_valid && err;

  assign mem_hi_unused = ^memdata[WIDTH-1:BYTE_W];

endmodule

// File: tb/tb_ls_access_ctrl.sv
// tb/tb_ls_access_ctrl.sv - scoreboard bench for ls_access_ctrl
module tb_ls_access_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_req_valid, s_req_ready, s_req_we, s_rsp_valid, s_rsp_ready, s_rsp_err;
  logic [31:0] s_req_adr, s_req_wdata, s_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [31:0] d_req_adr, d_req_wdata, d_rsp_rdata;
  logic [31:0] memdata, adr, writedata;
  logic        memread, memwrite;

  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  exp_t        s_q[$];
  exp_t        d_q[$];
  int          checks = 0;
  int          errors = 0;

  ls_access_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
    .s_req_adr(s_req_adr), .s_req_wdata(s_req_wdata), .s_rsp_valid(s_rsp_valid),
    .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_adr(d_req_adr), .d_req_wdata(d_req_wdata), .d_rsp_valid(d_rsp_valid),
    .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .memdata(memdata), .memread(memread), .memwrite(memwrite), .adr(adr), .writedata(writedata)
  );

  always #5 clk = ~clk;

  assign memdata = {24'h0, mem[adr[11:0]]};
  always @(posedge clk) if (memwrite) mem[adr[11:0]] <= writedata[7:0];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[a[11:0]], ref_mem[a[11:0]+1], ref_mem[a[11:0]+2], ref_mem[a[11:0]+3]};
  endfunction

  // Drives one request, waits for its grant, pushes the expected response.
  task automatic issue(input bit dma, input bit we, input logic [31:0] a, input logic [31:0] wd);
    int   n = 0;
    exp_t e;
    logic [31:0] aa;
    logic rdy;
    if (dma) begin d_req_we = we; d_req_adr = a; d_req_wdata = wd; d_req_valid = 1'b1; end
    else     begin s_req_we = we; s_req_adr = a; s_req_wdata = wd; s_req_valid = 1'b1; end
    #1;
    rdy = dma ? d_req_ready : s_req_ready;
    while (!rdy && n < 50) begin
      @(negedge clk); #1; n++;
      rdy = dma ? d_req_ready : s_req_ready;
    end
    checks++;
    if (!rdy) begin errors++; $display("FAIL grant_timeout port=%0d ready=%0b want 1", dma, rdy); end
    aa = a & ~32'h3;
    e.rdata = 32'h0; e.err = 1'b0;
`ifdef LS_MISALIGN_ERR_EN
    if (a[1:0] != 2'b00) e.err = 1'b1;
    else
`endif
    if (we) for (int i = 0; i < 4; i++) ref_mem[aa[11:0]+i] = wd[31-8*i -: 8];
    else e.rdata = ref_word(aa);
    if (dma) d_q.push_back(e); else s_q.push_back(e);
    @(posedge clk); #1;
    if (dma) d_req_valid = 1'b0; else s_req_valid = 1'b0;
  endtask

  // Waits for the port's response and compares it against the scoreboard head.
  task automatic wait_rsp(input bit dma, output int waited);
    exp_t e;
    logic v, ov;
    waited = 0;
    @(negedge clk);
    v = dma ? d_rsp_valid : s_rsp_valid;
    while (!v && waited < 40) begin
      @(negedge clk); waited++;
      v = dma ? d_rsp_valid : s_rsp_valid;
    end
    ov = dma ? s_rsp_valid : d_rsp_valid;
    e = dma ? d_q.pop_front() : s_q.pop_front();
    checks++;
    if (!v) begin errors++; $display("FAIL rsp_timeout port=%0d valid=%0b want 1", dma, v); end
    checks++;
    if ((dma ? d_rsp_rdata : s_rsp_rdata) !== e.rdata) begin
      errors++;
      $display("FAIL rsp_rdata port=%0d got %h want %h", dma, dma ? d_rsp_rdata : s_rsp_rdata, e.rdata);
    end
    checks++;
    if ((dma ? d_rsp_err : s_rsp_err) !== e.err) begin
      errors++;
      $display("FAIL rsp_err port=%0d got %0b want %0b", dma, dma ? d_rsp_err : s_rsp_err, e.err);
    end
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL other_rsp_valid got %0b want 0", ov); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({adr, writedata, memread, memwrite, s_req_ready, d_req_ready, s_rsp_valid, d_rsp_valid,
         s_rsp_rdata, d_rsp_rdata, s_rsp_err, d_rsp_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs adr=%h wd=%h rd=%0b wr=%0b want all 0", adr, writedata, memread, memwrite);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spu_load;
    int w;
    issue(1'b0, 1'b0, 32'h100, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (adr !== 32'h100 + i || memread !== 1'b1 || memwrite !== 1'b0) begin
        errors++;
        $display("FAIL load_beat%0d adr=%h rd=%0b wr=%0b want %h 1 0", i, adr, memread, memwrite, 32'h100 + i);
      end
    end
    wait_rsp(1'b0, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL load_latency extra=%0d want 0", w); end
  endtask

  task automatic test_dma_store;
    int w;
    logic [31:0] wd;
    wd = 32'hA1B2C3D4;
    issue(1'b1, 1'b1, 32'h204, wd);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (adr !== 32'h204 + i || memwrite !== 1'b1 || memread !== 1'b0 || writedata !== {24'h0, wd[31-8*i -: 8]}) begin
        errors++;
        $display("FAIL store_beat%0d adr=%h wr=%0b wd=%h want %h 1 %h", i, adr, memwrite, writedata,
                 32'h204 + i, wd[31-8*i -: 8]);
      end
    end
    wait_rsp(1'b1, w);
  endtask

  task automatic test_back_to_back;
    int   grants[$];
    int   nrsp = 0;
    int   cyc = 0;
    exp_t e;
    e.err = 1'b0;
    e.rdata = ref_word(32'h100); s_q.push_back(e); s_q.push_back(e);
    e.rdata = ref_word(32'h204); d_q.push_back(e); d_q.push_back(e);
    s_req_we = 1'b0; s_req_adr = 32'h100; d_req_we = 1'b0; d_req_adr = 32'h204;
    @(negedge clk);
    s_req_valid = 1'b1; d_req_valid = 1'b1;
    while ((grants.size() < 4 || nrsp < 4) && cyc < 200) begin
      #1;
      if (grants.size() >= 4) begin s_req_valid = 1'b0; d_req_valid = 1'b0; #1; end
      checks++;
      if (s_req_ready && d_req_ready) begin errors++; $display("FAIL double_ready both=1 want one"); end
      if (s_req_ready) grants.push_back(0);
      if (d_req_ready) grants.push_back(1);
      if (s_rsp_valid || d_rsp_valid) begin
        e = s_rsp_valid ? s_q.pop_front() : d_q.pop_front();
        checks++;
        if ((s_rsp_valid ? s_rsp_rdata : d_rsp_rdata) !== e.rdata) begin
          errors++;
          $display("FAIL b2b_rdata got %h want %h", s_rsp_valid ? s_rsp_rdata : d_rsp_rdata, e.rdata);
        end
        nrsp++;
      end
      @(negedge clk); cyc++;
    end
    s_req_valid = 1'b0; d_req_valid = 1'b0;
    checks++;
    if (grants.size() != 4 || nrsp != 4) begin
      errors++; $display("FAIL b2b_count grants=%0d rsps=%0d want 4 4", grants.size(), nrsp);
    end
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      checks++;
      if (grants[i] != i % 2) begin errors++; $display("FAIL b2b_order%0d got %0d want %0d", i, grants[i], i % 2); end
    end
  endtask

  task automatic test_rsp_backpressure;
    int   n = 0;
    int   w;
    exp_t e;
    s_rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 32'h100, 32'h0);
    d_req_we = 1'b0; d_req_adr = 32'h204; d_req_valid = 1'b1;
    @(negedge clk);
    while (!s_rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (s_rsp_valid !== 1'b1 || s_rsp_rdata !== 32'h11223344 || d_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d valid=%0b rdata=%h dready=%0b want 1 11223344 0", i, s_rsp_valid, s_rsp_rdata, d_req_ready);
      end
      @(negedge clk);
    end
    e = s_q.pop_front();
    checks++;
    if (s_rsp_rdata !== e.rdata) begin errors++; $display("FAIL hold_rdata got %h want %h", s_rsp_rdata, e.rdata); end
    s_rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b1 || s_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL dma_after_release dready=%0b svalid=%0b want 1 0", d_req_ready, s_rsp_valid);
    end
    e.rdata = ref_word(32'h204); e.err = 1'b0; d_q.push_back(e);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    wait_rsp(1'b1, w);
  endtask

  task automatic test_misalign;
    int w;
    issue(1'b0, 1'b0, 32'h102, 32'h0);
`ifdef LS_MISALIGN_ERR_EN
    checks++;
    if (memread !== 1'b0 || memwrite !== 1'b0 || adr !== 32'h0) begin
      errors++; $display("FAIL misalign_beats rd=%0b wr=%0b adr=%h want 0 0 0", memread, memwrite, adr);
    end
    wait_rsp(1'b0, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL misalign_latency extra=%0d want 0", w); end
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (adr !== 32'h100 + i || memread !== 1'b1) begin
        errors++; $display("FAIL misalign_beat%0d adr=%h rd=%0b want %h 1", i, adr, memread, 32'h100 + i);
      end
    end
    wait_rsp(1'b0, w);
`endif
  endtask

  task automatic test_reset_mid_store;
    int w;
    exp_t e;
    issue(1'b0, 1'b1, 32'h300, 32'h55667788);
    void'(s_q.pop_back());
    for (int i = 0; i < 4; i++) ref_mem[12'h300+i] = 8'h00;
    ref_mem[12'h300] = 8'h55; ref_mem[12'h301] = 8'h66;
    repeat (3) @(negedge clk);
    checks++;
    if (memwrite !== 1'b1 || adr !== 32'h302) begin
      errors++; $display("FAIL beat2_setup wr=%0b adr=%h want 1 00000302", memwrite, adr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (memwrite !== 1'b0 || adr !== 32'h0 || s_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_abort wr=%0b adr=%h rv=%0b want 0 0 0", memwrite, adr, s_rsp_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (s_rsp_valid !== 1'b0 || s_req_ready !== 1'b0) begin
        errors++; $display("FAIL no_rsp_after_reset rv=%0b ready=%0b want 0 0", s_rsp_valid, s_req_ready);
      end
    end
    issue(1'b0, 1'b0, 32'h300, 32'h0);
    e = s_q[$];
    checks++;
    if (e.rdata !== 32'h55660000) begin errors++; $display("FAIL partial_model got %h want 55660000", e.rdata); end
    wait_rsp(1'b0, w);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    for (int i = 0; i < 4; i++) ref_mem[12'h100+i] = mem[12'h100+i];
    s_req_valid = 1'b0; s_req_we = 1'b0; s_req_adr = '0; s_req_wdata = '0; s_rsp_ready = 1'b1;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_adr = '0; d_req_wdata = '0; d_rsp_ready = 1'b1;
    test_reset();
    test_spu_load();
    test_dma_store();
    test_back_to_back();
    test_rsp_backpressure();
    test_misalign();
    test_reset_mid_store();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
